uart_rx_fifo_ctrl: RTL and testbench

Receive-side buffer controller between the UART receiver and the host register interface, in the 16550 style. Captures each received character and its pe/fe/bi status into a FIFO, and maintains the line-status bits DR, OE and error-in-FIFO. Generates the receive-data-available interrupt at a programmable trigger level and the character-timeout interrupt, using the receiver's 16x baud_pulse as time base. With FIFO disabled it degrades to a single holding register.

---
 rtl/uart_rx_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// 16550-style receive buffer: character + {bi,fe,pe} FIFO with line-status bits,
// trigger-level and character-timeout interrupts. Collapses to one holding register when fifo_en=0.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_pulse,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic [1:0]    trig_lvl,
  input  logic [1:0]    wls,
  input  logic          pen,
  input  logic          rd,
  input  logic          lsr_rd,
  output logic [7:0]    rdata,
  output logic [2:0]    rerr,
  output logic          dr,
  output logic          oe,
  output logic          err_in_fifo,
  output logic [AW:0]   level,
  output logic          rda_irq,
  output logic          cto_irq
);

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  rx_entry_t       mem [DEPTH];
  rx_entry_t       head;
  rx_entry_t       wr_entry;
  logic [AW-1:0]   rd_ptr, wr_ptr, wr_addr;
  logic [AW:0]     err_cnt;
  logic [AW:0]     trig;
  logic [9:0]      tmo_cnt;
  logic [9:0]      limit;
  logic [3:0]      char_bits;
  logic            fifo_en_q;
  logic            flush, full, pop, wr_new, overrun, overwrite;
  logic            err_inc, err_dec;

  assign head     = mem[rd_ptr];
  assign wr_entry = '{bi: bi_in, fe: fe_in, pe: pe_in, data: din};
  assign rdata    = head.data;
  assign rerr     = {head.bi, head.fe, head.pe};

  // A mode change invalidates everything stored, so it flushes like fifo_clr.
  assign flush     = fifo_clr | (fifo_en ^ fifo_en_q);
  assign dr        = (level != '0);
  assign full      = fifo_en ? (level == FULL_LVL) : dr;
  assign pop       = rd & dr & ~flush;
  assign wr_new    = push & ~flush & (~full | pop);
  assign overrun   = push & ~flush & full & ~pop;
  assign overwrite = overrun & ~fifo_en;
  // The holding-register overwrite lands on the head slot, not the tail.
  assign wr_addr   = overwrite ? rd_ptr : wr_ptr;

  // Overwrite swaps the head entry, so it can both add and remove an errored entry.
  assign err_inc = (wr_new | overwrite) & (pe_in | fe_in | bi_in);
  assign err_dec = (pop | overwrite) & (|rerr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_new | overwrite) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      err_cnt   <= '0;
      oe        <= 1'b0;
      fifo_en_q <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en;
      if (overrun)     oe <= 1'b1;
      else if (lsr_rd) oe <= 1'b0;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        level   <= '0;
        err_cnt <= '0;
      end else begin
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        if (wr_new) wr_ptr <= wr_ptr + 1'b1;
        if (wr_new && !pop)      level <= level + 1'b1;
        else if (pop && !wr_new) level <= level - 1'b1;
        err_cnt <= err_cnt + (AW+1)'(err_inc) - (AW+1)'(err_dec);
      end
    end
  end

  assign err_in_fifo = (err_cnt != '0);

  always_comb begin
    trig = '0;
    case (trig_lvl)
      2'b00: trig = (AW+1)'(1);
      2'b01: trig = (AW+1)'(4);
      2'b10: trig = (AW+1)'(8);
      default: trig = (AW+1)'(14);
    endcase
  end

  assign rda_irq = fifo_en ? (level >= trig) : dr;

  // Four character times = 64 baud ticks per bit; recomputed live from wls/pen.
  assign char_bits = 4'd7 + {2'b00, wls} + {3'b000, pen};
  assign limit     = {char_bits, 6'b000000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (flush || push || rd || level == '0)
      tmo_cnt <= '0;
    else if (baud_pulse && tmo_cnt < limit)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign cto_irq = fifo_en & dr & (tmo_cnt >= limit);

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: ordering, trigger, overrun, error tracking,
// character timeout, non-FIFO mode, flush and async reset.
module tb_uart_rx_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst, baud_pulse, push, pe_in, fe_in, bi_in;
  logic       fifo_en, fifo_clr, pen, rd, lsr_rd;
  logic [7:0] din, rdata;
  logic [1:0] trig_lvl, wls;
  logic [2:0] rerr;
  logic       dr, oe, err_in_fifo, rda_irq, cto_irq;
  logic [4:0] level;
  int         errors = 0;
  int         checks = 0;

  uart_rx_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .push(push), .din(din),
    .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .fifo_en(fifo_en),
    .fifo_clr(fifo_clr), .trig_lvl(trig_lvl), .wls(wls), .pen(pen), .rd(rd),
    .lsr_rd(lsr_rd), .rdata(rdata), .rerr(rerr), .dr(dr), .oe(oe),
    .err_in_fifo(err_in_fifo), .level(level), .rda_irq(rda_irq), .cto_irq(cto_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ch(input logic [7:0] d, input logic [2:0] st);
    din = d; {bi_in, fe_in, pe_in} = st; push = 1'b1;
    tick();
    push = 1'b0; {bi_in, fe_in, pe_in} = 3'b000;
  endtask

  task automatic do_rd();
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic do_clr();
    fifo_clr = 1'b1; tick(); fifo_clr = 1'b0;
  endtask

  task automatic baud_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      baud_pulse = 1'b1; tick();
      baud_pulse = 1'b0; tick();
    end
  endtask

  initial begin
    rst = 1'b1; baud_pulse = 0; push = 0; din = 0; pe_in = 0; fe_in = 0; bi_in = 0;
    fifo_en = 0; fifo_clr = 0; trig_lvl = 2'b00; wls = 2'b00; pen = 0; rd = 0; lsr_rd = 0;
    #12;
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_dr", 16'(dr), 16'd0);
    chk("rst_oe", 16'(oe), 16'd0);
    chk("rst_rdata", 16'(rdata), 16'd0);
    chk("rst_cto", 16'(cto_irq), 16'd0);
    rst = 1'b0;
    fifo_en = 1'b1;
    tick(); tick();

    // In-order delivery
    push_ch(8'h41, 3'b000);
    chk("head_after_push", 16'(rdata), 16'h41);
    push_ch(8'h42, 3'b000);
    push_ch(8'h43, 3'b000);
    chk("lvl3", 16'(level), 16'd3);
    chk("dr1", 16'(dr), 16'd1);
    chk("rd0", 16'(rdata), 16'h41); do_rd();
    chk("rd1", 16'(rdata), 16'h42); do_rd();
    chk("rd2", 16'(rdata), 16'h43); do_rd();
    chk("lvl0", 16'(level), 16'd0);
    chk("dr0", 16'(dr), 16'd0);
    do_rd();
    chk("rd_empty_ignored", 16'(level), 16'd0);

    // Trigger level 4
    trig_lvl = 2'b01;
    for (int i = 0; i < 3; i++) push_ch(8'(8'h30 + i), 3'b000);
    chk("rda_at3", 16'(rda_irq), 16'd0);
    push_ch(8'h33, 3'b000);
    chk("rda_at4", 16'(rda_irq), 16'd1);
    do_rd();
    chk("rda_after_rd", 16'(rda_irq), 16'd0);
    do_clr();
    chk("clr_level", 16'(level), 16'd0);

    // Full / overrun
    for (int i = 0; i < 16; i++) push_ch(8'(8'h60 + i), 3'b000);
    chk("full_lvl", 16'(level), 16'd16);
    push_ch(8'h55, 3'b000);
    chk("ovr_oe", 16'(oe), 16'd1);
    chk("ovr_lvl", 16'(level), 16'd16);
    chk("ovr_head", 16'(rdata), 16'h60);
    lsr_rd = 1'b1; tick(); lsr_rd = 1'b0;
    chk("lsr_clr_oe", 16'(oe), 16'd0);
    din = 8'h77; push = 1'b1; rd = 1'b1; tick(); push = 1'b0; rd = 1'b0;
    chk("full_pushrd_oe", 16'(oe), 16'd0);
    chk("full_pushrd_lvl", 16'(level), 16'd16);
    chk("full_pushrd_head", 16'(rdata), 16'h61);
    do_clr();
    chk("clr_full_lvl", 16'(level), 16'd0);

    // Error tracking
    push_ch(8'h10, 3'b010);
    push_ch(8'h20, 3'b000);
    chk("eif_set", 16'(err_in_fifo), 16'd1);
    chk("rerr_fe", 16'(rerr), 16'b010);
    do_rd();
    chk("rerr_clean", 16'(rerr), 16'd0);
    chk("eif_clr", 16'(err_in_fifo), 16'd0);
    chk("rdata_20", 16'(rdata), 16'h20);
    do_rd();

    // Character timeout: 11-bit chars -> limit 704
    wls = 2'b11; pen = 1'b1;
    push_ch(8'h5A, 3'b000);
    baud_ticks(450);
    chk("cto_450", 16'(cto_irq), 16'd0);
    wls = 2'b00; pen = 1'b0;
    tick();
    chk("cto_shrunk_limit", 16'(cto_irq), 16'd1);
    wls = 2'b11; pen = 1'b1;
    tick();
    chk("cto_restored_limit", 16'(cto_irq), 16'd0);
    baud_ticks(253);
    chk("cto_703", 16'(cto_irq), 16'd0);
    baud_ticks(1);
    chk("cto_704", 16'(cto_irq), 16'd1);
    baud_ticks(5);
    chk("cto_sat", 16'(cto_irq), 16'd1);
    do_rd();
    chk("cto_after_rd", 16'(cto_irq), 16'd0);
    chk("cto_rd_lvl", 16'(level), 16'd0);

    // Holding-register mode
    fifo_en = 1'b0; tick();
    push_ch(8'hAA, 3'b000);
    push_ch(8'hBB, 3'b000);
    chk("nf_rdata", 16'(rdata), 16'hBB);
    chk("nf_oe", 16'(oe), 16'd1);
    chk("nf_lvl", 16'(level), 16'd1);
    chk("nf_rda", 16'(rda_irq), 16'd1);
    do_clr();
    chk("nf_clr_lvl", 16'(level), 16'd0);
    chk("nf_clr_oe", 16'(oe), 16'd1);

    // Async reset mid-timeout
    fifo_en = 1'b1; tick();
    push_ch(8'hC3, 3'b001);
    baud_ticks(100);
    rst = 1'b1; #1;
    chk("arst_lvl", 16'(level), 16'd0);
    chk("arst_dr", 16'(dr), 16'd0);
    chk("arst_oe", 16'(oe), 16'd0);
    chk("arst_rdata", 16'(rdata), 16'd0);
    chk("arst_rerr", 16'(rerr), 16'd0);
    chk("arst_eif", 16'(err_in_fifo), 16'd0);
    chk("arst_cto", 16'(cto_irq), 16'd0);
    chk("arst_rda", 16'(rda_irq), 16'd0);
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
